// File: rtl/clock_meas_pkg.sv
// Shared definitions for clock measurement blocks: FSM state type,
// default counter width, minimum synchronizer depth and a small helper
// for the lock match counter.
package clock_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEEK,
        ST_MEASURE
    } meas_state_t;

    localparam int DEFAULT_WIDTH   = 16;
    localparam int MIN_SYNC_STAGES = 2;

    // Two-bit match counter: counts consecutive matches up to 2, clears on a miss.
    function automatic logic [1:0] match_next(input logic [1:0] cur, input logic hit);
        if (!hit) begin
            return 2'd0;
        end
        return (cur == 2'd2) ? 2'd2 : cur + 2'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizes an asynchronous level into the clk_in domain and flags
// every transition (both polarities) as a one-cycle sig_edge.
// Depth below MIN_SYNC_STAGES is clamped up to the minimum.
module sync_edge_detect
    import clock_meas_pkg::*;
#(
    parameter int STAGES = MIN_SYNC_STAGES
) (
    input  logic clk_in,
    input  logic reset,
    input  logic sig_in,
    output logic sig_edge
);

    localparam int N = (STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : STAGES;

    logic [N-1:0] sync_q;
    logic         s_prev_q;

    // Synchronizer chain plus one extra register holding the previous synchronized level.
    always_ff @(posedge clk_in) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[N-2:0], sig_in};
            s_prev_q <= sync_q[N-1];
        end
    end

    assign sig_edge = sync_q[N-1] ^ s_prev_q;

endmodule

// File: rtl/clock_period_meter.sv
// Measures the half-period of a slow asynchronous square wave in clk_in
// cycles. Result matches the divider 'half' setting that produced it.
// Optional lock detection is built when CLOCK_PERIOD_METER_LOCK_EN is
// defined; otherwise 'locked' is tied low.
module clock_period_meter
    import clock_meas_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TOL         = 0
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] half_count,
    output logic             valid,
    output logic             timeout,
    output logic             locked
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    meas_state_t      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] half_q, half_d;
    logic             valid_q, valid_d;
    logic             timeout_q, timeout_d;
    logic             sig_edge;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_in   (clk_in),
        .reset    (reset),
        .sig_in   (sig_in),
        .sig_edge (sig_edge)
    );

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter and result updates; an edge beats saturation.
    always_comb begin
        // NOTE: every value written here gets a default first, so no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d   = '0;
                    state_d = ST_SEEK;
                end
                ST_SEEK: begin
                    if (sig_edge) begin
                        cnt_d   = '0;
                        state_d = ST_MEASURE;
                    end
                end
                ST_MEASURE: begin
                    if (sig_edge) begin
                        half_d  = cnt_q;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_SEEK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Counter, result and pulse registers; a partial count never survives reset.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            cnt_q     <= '0;
            half_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            half_q    <= half_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign half_count = half_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;

`ifdef CLOCK_PERIOD_METER_LOCK_EN
    localparam logic [WIDTH-1:0] TOL_W = WIDTH'(TOL);

    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] diff;
    logic             hit;
    logic [1:0]       match_q;

    // Absolute difference between the newest result and the one before it.
    always_comb begin
        diff = (half_q >= last_q) ? (half_q - last_q) : (last_q - half_q);
        hit  = (diff <= TOL_W);
    end

    // Match counter updates the cycle after each valid, so locked follows one cycle later.
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            match_q <= 2'd0;
            last_q  <= '0;
        end else if (!enable || timeout_d) begin
            match_q <= 2'd0;
        end else if (valid_q) begin
            match_q <= match_next(match_q, hit);
            last_q  <= half_q;
        end
    end

    assign locked = (match_q == 2'd2);
`else
    assign locked = 1'b0;
`endif

endmodule
